capacitive_sensor_scanner: RTL and testbench
============================================

Name: capacitive_sensor_scanner

Overview:
Front-end for the nine whack-a-mole touch pads. Drives the shared charge line (capacitive_sensors_out) and times each pad's discharge on capacitive_sensors_in. Debounces each pad and raises sticky hit flags for the processor, which clears them by mask once a hit is consumed. Sits directly upstream of the processor: the skeleton maps touch_level and hit_pending into the processor's memory-mapped input space.

Parameters:
NUM_PADS, 9, number of pads/sensor inputs
CNT_W, 10, width of the discharge counter
CHARGE_CYCLES, 64, cycles the charge line is held high per scan
TIMEOUT, 1023, maximum MEASURE count; must be at most 2^CNT_W-1
THRESH, 200, discharge count at or above which a pad reads as touched
DEBOUNCE, 3, consecutive agreeing scans required to change a pad's touch_level
GAP_CYCLES, 16, idle cycles between scans

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-low reset
enable  in  1  start or continue scanning while high
capacitive_sensors_in  in  NUM_PADS  raw pad inputs (asynchronous)
capacitive_sensors_out  out  1  charge line
hit_clear  in  NUM_PADS  per-pad clear strobe for hit_pending
touch_level  out  NUM_PADS  debounced touched state
hit_pending  out  NUM_PADS  sticky flag, set on a touch_level rising edge
scan_done  out  1  one-cycle pulse after each EVAL
pad_counts  out  NUM_PADS*CNT_W  last measured counts; pad i occupies bits [i*CNT_W +: CNT_W]

Behaviour:
- Reset is taken on the rising edge of clock when reset==0. It clears all outputs, counters, synchronizers and debounce state to 0 and puts the FSM in IDLE. Reset has priority over everything, including mid-scan; the charge line drops low on the next edge.
- Each capacitive_sensors_in bit passes through a 2-FF synchronizer. All measurement uses the synchronized value.
- FSM states: IDLE, CHARGE, MEASURE, EVAL, GAP.
  - IDLE: out=0. When enable=1, go to CHARGE on the next edge.
  - CHARGE: out=1 for exactly CHARGE_CYCLES cycles, then MEASURE.
  - MEASURE: out=0. Counter m starts at 0 in the first MEASURE cycle and increments by 1 each cycle.
    - Pad i captures count_i=m in the first MEASURE cycle in which its synchronized input is 0.
    - Capture happens only once per scan.
    - Leave MEASURE after the cycle in which all pads have captured, or in which m==TIMEOUT. Uncaptured pads get count_i=TIMEOUT.
  - EVAL: one cycle.
    - raw_i = (count_i >= THRESH).
    - pad_counts is updated.
    - Debounce is applied (see below).
    - scan_done pulses in the cycle after EVAL (the first GAP cycle).
  - GAP: GAP_CYCLES cycles, then CHARGE if enable=1, else IDLE.
- Dropping enable mid-scan does not abort: the scan completes through EVAL/GAP, then the FSM goes to IDLE.
- Debounce, per pad, using a saturating agree counter:
  - If raw_i differs from touch_level_i, increment the counter. When it reaches DEBOUNCE, toggle touch_level_i and zero the counter.
  - If raw_i equals touch_level_i, zero the counter.
- hit_pending_i is set in the cycle touch_level_i goes 0->1.
  - hit_clear_i=1 clears it.
  - Set and clear in the same cycle: set wins.
- Width rules:
  - m never exceeds TIMEOUT; no wrap.
  - Comparisons are unsigned.

Decomposition:
- Shared package holds:
  - the state encoding for the five FSM states (3-bit);
  - default constants: NUM_PADS, CNT_W, THRESH, DEBOUNCE.
- One sub-module is natural: pad_debounce (per-pad agree counter, touch_level bit, hit_pending bit, hit_clear handling), instantiated NUM_PADS times via generate.
- The FSM, synchronizers and capture logic stay in the top module.

Test Plan:
Bench parameters for all cases: CHARGE_CYCLES=4, TIMEOUT=31, THRESH=10, DEBOUNCE=2, GAP_CYCLES=2.
1. Reset: hold reset=0 with enable=1 for 3 cycles -> capacitive_sensors_out=0, touch_level=0, hit_pending=0, pad_counts=0, scan_done=0.
2. Idle pads: all inputs go low as soon as the charge line falls, two scans -> every pad_counts field < 10, touch_level=9'h000, two scan_done pulses. Each pulse follows its scan's CHARGE start by 4 charge + MEASURE cycles + 1 EVAL + 1.
3. Touch on pad 3: pad 3 held high 15 cycles into MEASURE, others low immediately, on two consecutive scans -> after scan 1, touch_level=0; after scan 2 EVAL, touch_level=9'h008 and hit_pending=9'h008.
4. Stuck-high pad 8: pad 8 never falls -> pad 8's count field=31, and MEASURE exits at m==31 exactly. Set and clear: pulse hit_clear=9'h100 in the same cycle pad 8's touch_level rises -> hit_pending[8] stays 1; a later pulse clears it.
5. Glitch rejection and release: pad 0 touched for only one scan -> touch_level stays 0. After pad 3 is latched, two untouched scans -> touch_level[3]=0 while hit_pending[3] remains 1.
6. Mid-operation: drop enable during CHARGE -> the scan completes, then IDLE with out=0. Assert reset=0 during MEASURE -> next cycle IDLE and all outputs 0.

Source files
------------

// File: rtl/capacitive_sensor_scanner_pkg.sv
// Shared definitions for the capacitive pad scanner: scan FSM encoding and
// default sizing constants used by the top level and the per-pad debouncer.
package capacitive_sensor_scanner_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CHARGE  = 3'd1,
        ST_MEASURE = 3'd2,
        ST_EVAL    = 3'd3,
        ST_GAP     = 3'd4
    } scan_state_t;

    localparam int DEF_NUM_PADS = 9;
    localparam int DEF_CNT_W    = 10;
    localparam int DEF_THRESH   = 200;
    localparam int DEF_DEBOUNCE = 3;

endpackage

// File: rtl/capacitive_sensor_scanner_debounce.sv
// Per-pad debouncer: counts consecutive scans whose raw reading disagrees with
// the current level, toggles the level after DEBOUNCE of them, and keeps a
// sticky hit flag raised on every 0->1 level change until the processor clears it.
module capacitive_sensor_scanner_debounce
    import capacitive_sensor_scanner_pkg::*;
#(
    parameter int DEBOUNCE = DEF_DEBOUNCE
) (
    input  logic clock,
    input  logic reset,
    input  logic eval,
    input  logic raw,
    input  logic hit_clear,
    output logic touch_level,
    output logic hit_pending
);

    // Counter only ever holds 0..DEBOUNCE-1: it is zeroed when it would reach DEBOUNCE.
    localparam int AW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

    logic [AW-1:0] agree_cnt;
    logic          will_toggle;
    logic          rise;

    // Decide whether this scan's result completes a level change.
    always_comb begin
        will_toggle = 1'b0;
        rise        = 1'b0;
        if (eval && (raw != touch_level) && (agree_cnt == AW'(DEBOUNCE - 1))) begin
            will_toggle = 1'b1;
            rise        = ~touch_level;
        end
    end

    // Agree counter, debounced level and sticky hit flag (a new hit beats a clear).
    always_ff @(posedge clock) begin
        if (!reset) begin
            agree_cnt   <= '0;
            touch_level <= 1'b0;
            hit_pending <= 1'b0;
        end else begin
            if (eval) begin
                if (raw == touch_level) begin
                    agree_cnt <= '0;
                end else if (will_toggle) begin
                    agree_cnt   <= '0;
                    touch_level <= ~touch_level;
                end else begin
                    agree_cnt <= agree_cnt + AW'(1);
                end
            end
            if (rise) begin
                hit_pending <= 1'b1;
            end else if (hit_clear) begin
                hit_pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/capacitive_sensor_scanner.sv
// Touch-pad front end: charges the shared line, times each pad's discharge,
// evaluates the counts against THRESH and hands the results to the debouncers.
module capacitive_sensor_scanner
    import capacitive_sensor_scanner_pkg::*;
#(
    parameter int NUM_PADS      = DEF_NUM_PADS,
    parameter int CNT_W         = DEF_CNT_W,
    parameter int CHARGE_CYCLES = 64,
    parameter int TIMEOUT       = 1023,
    parameter int THRESH        = DEF_THRESH,
    parameter int DEBOUNCE      = DEF_DEBOUNCE,
    parameter int GAP_CYCLES    = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [NUM_PADS-1:0]       capacitive_sensors_in,
    output logic                      capacitive_sensors_out,
    input  logic [NUM_PADS-1:0]       hit_clear,
    output logic [NUM_PADS-1:0]       touch_level,
    output logic [NUM_PADS-1:0]       hit_pending,
    output logic                      scan_done,
    output logic [NUM_PADS*CNT_W-1:0] pad_counts
);

    // One timer serves both the CHARGE and GAP phases.
    localparam int TMAX = (CHARGE_CYCLES > GAP_CYCLES) ? CHARGE_CYCLES : GAP_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    scan_state_t         state, state_nxt;
    logic [NUM_PADS-1:0] sync_p0, sync_p1;
    logic [TW-1:0]       timer;
    logic [CNT_W-1:0]    m_cnt;
    logic [NUM_PADS-1:0] captured;
    logic [NUM_PADS-1:0] capture_now;
    logic [CNT_W-1:0]    cap_cnt [NUM_PADS];
    logic [NUM_PADS-1:0] raw;
    logic                all_done;
    logic                at_timeout;
    logic                eval;

    // Two-flop synchronizer on the asynchronous pad inputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= capacitive_sensors_in;
            sync_p1 <= sync_p0;
        end
    end

    // Capture qualifiers: first low reading of each still-open pad during MEASURE.
    always_comb begin
        capture_now = '0;
        if (state == ST_MEASURE) begin
            capture_now = ~captured & ~sync_p1;
        end
        all_done   = &(captured | capture_now);
        at_timeout = (m_cnt == CNT_W'(TIMEOUT));
        eval       = (state == ST_EVAL);
        for (int i = 0; i < NUM_PADS; i++) begin
            raw[i] = (cap_cnt[i] >= CNT_W'(THRESH));
        end
    end

    // Next-state and charge-line drive.
    always_comb begin
        state_nxt              = state;
        capacitive_sensors_out = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enable) state_nxt = ST_CHARGE;
            end
            ST_CHARGE: begin
                capacitive_sensors_out = 1'b1;
                if (timer == TW'(CHARGE_CYCLES - 1)) state_nxt = ST_MEASURE;
            end
            ST_MEASURE: begin
                if (all_done || at_timeout) state_nxt = ST_EVAL;
            end
            ST_EVAL: begin
                state_nxt = ST_GAP;
            end
            ST_GAP: begin
                if (timer == TW'(GAP_CYCLES - 1)) begin
                    state_nxt = enable ? ST_CHARGE : ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Phase timer for CHARGE/GAP and the discharge counter m for MEASURE;
    // both restart from 0 whenever their phase is (re)entered.
    always_ff @(posedge clock) begin
        if (!reset) begin
            timer <= '0;
            m_cnt <= '0;
        end else begin
            if ((state_nxt == state) && ((state == ST_CHARGE) || (state == ST_GAP))) begin
                timer <= timer + TW'(1);
            end else begin
                timer <= '0;
            end
            if ((state == ST_MEASURE) && (state_nxt == ST_MEASURE)) begin
                m_cnt <= m_cnt + CNT_W'(1);
            end else begin
                m_cnt <= '0;
            end
        end
    end

    // Per-pad capture: preload TIMEOUT during CHARGE so pads that never
    // discharge read as TIMEOUT, then latch m once on the first low reading.
    always_ff @(posedge clock) begin
        if (!reset) begin
            captured <= '0;
            for (int i = 0; i < NUM_PADS; i++) begin
                cap_cnt[i] <= '0;
            end
        end else if (state == ST_CHARGE) begin
            captured <= '0;
            for (int i = 0; i < NUM_PADS; i++) begin
                cap_cnt[i] <= CNT_W'(TIMEOUT);
            end
        end else begin
            captured <= captured | capture_now;
            for (int i = 0; i < NUM_PADS; i++) begin
                if (capture_now[i]) cap_cnt[i] <= m_cnt;
            end
        end
    end

    // Publish counts at EVAL and pulse scan_done in the following cycle.
    always_ff @(posedge clock) begin
        if (!reset) begin
            pad_counts <= '0;
            scan_done  <= 1'b0;
        end else begin
            scan_done <= eval;
            if (eval) begin
                for (int i = 0; i < NUM_PADS; i++) begin
                    pad_counts[i*CNT_W +: CNT_W] <= cap_cnt[i];
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_PADS; g++) begin : g_pad
        capacitive_sensor_scanner_debounce #(
            .DEBOUNCE(DEBOUNCE)
        ) u_debounce (
            .clock       (clock),
            .reset       (reset),
            .eval        (eval),
            .raw         (raw[g]),
            .hit_clear   (hit_clear[g]),
            .touch_level (touch_level[g]),
            .hit_pending (hit_pending[g])
        );
    end

endmodule

// File: tb/tb_capacitive_sensor_scanner.sv
// Bench for capacitive_sensor_scanner: a scan-level model predicts every
// output cycle by cycle from each pad's discharge delay; a negedge process
// compares the DUT against it, with literal checks pinning key results.
module tb_capacitive_sensor_scanner;

    localparam int NP = 9;
    localparam int CW = 10;
    localparam int CH = 4;
    localparam int TO = 31;
    localparam int TH = 10;
    localparam int DB = 2;
    localparam int GP = 2;
    localparam int STUCK = 1000;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              enable = 1'b1;
    logic [NP-1:0]     sens_in = '1;
    logic [NP-1:0]     hit_clear = '0;
    logic              cs_out;
    logic [NP-1:0]     touch_level;
    logic [NP-1:0]     hit_pending;
    logic              scan_done;
    logic [NP*CW-1:0]  pad_counts;

    capacitive_sensor_scanner #(
        .NUM_PADS(NP), .CNT_W(CW), .CHARGE_CYCLES(CH), .TIMEOUT(TO),
        .THRESH(TH), .DEBOUNCE(DB), .GAP_CYCLES(GP)
    ) dut (
        .clock                  (clock),
        .reset                  (reset),
        .enable                 (enable),
        .capacitive_sensors_in  (sens_in),
        .capacitive_sensors_out (cs_out),
        .hit_clear              (hit_clear),
        .touch_level            (touch_level),
        .hit_pending            (hit_pending),
        .scan_done              (scan_done),
        .pad_counts             (pad_counts)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit chk_en = 0;
    int sd_seen = 0;
    int sd_cyc = 0;
    int scan_start = 0;

    logic             exp_out, exp_sd;
    logic [NP-1:0]    exp_touch, exp_hit;
    logic [NP*CW-1:0] exp_counts;
    int               m_agree [NP];
    int               hv [NP];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, req, cyc);
        end
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            chk("charge_line", cs_out, exp_out);
            chk("scan_done", scan_done, exp_sd);
            chk("touch_level", touch_level, exp_touch);
            chk("hit_pending", hit_pending, exp_hit);
            chk("pad_counts", pad_counts, exp_counts);
            if (scan_done === 1'b1) begin
                sd_seen++;
                sd_cyc = cyc;
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic model_reset();
        exp_out    = 1'b0;
        exp_sd     = 1'b0;
        exp_touch  = '0;
        exp_hit    = '0;
        exp_counts = '0;
        for (int i = 0; i < NP; i++) m_agree[i] = 0;
    endtask

    // One IDLE cycle with enable raised so the next cycle starts a scan.
    task automatic start();
        step();
        hit_clear = '0;
        sens_in   = '1;
        enable    = 1'b1;
    endtask

    task automatic idle_clear(input logic [NP-1:0] mask);
        step();
        hit_clear = mask;
        step();
        hit_clear = '0;
        exp_hit   = exp_hit & ~mask;
    endtask

    // One full scan. Pad i is held high for hv[i] MEASURE cycles and then
    // released; the two-flop synchronizer makes the capture land at hv[i]+2.
    task automatic scan(input bit drop_en, input bit en_next,
                        input logic [NP-1:0] clr_eval, input logic [NP-1:0] clr_gap,
                        input int abort_at);
        int cnt [NP];
        int mx;
        logic [NP-1:0]    nt;
        logic [NP-1:0]    rise;
        logic [NP*CW-1:0] newc;
        bit raw;
        mx = 0;
        for (int i = 0; i < NP; i++) begin
            cnt[i] = (hv[i] + 2 > TO) ? TO : hv[i] + 2;
            if (cnt[i] > mx) mx = cnt[i];
        end
        for (int c = 0; c < CH; c++) begin
            step();
            if (c == 0) scan_start = cyc;
            sens_in   = '1;
            hit_clear = '0;
            exp_out   = 1'b1;
            exp_sd    = 1'b0;
            if (drop_en && c == 1) enable = 1'b0;
        end
        for (int m = 0; m <= mx; m++) begin
            step();
            exp_out = 1'b0;
            for (int i = 0; i < NP; i++) sens_in[i] = (m < hv[i]);
            if (m == abort_at) begin
                reset = 1'b0;
                step();
                model_reset();
                reset   = 1'b1;
                enable  = 1'b0;
                sens_in = '1;
                return;
            end
        end
        step();
        sens_in   = '1;
        hit_clear = clr_eval;
        nt   = exp_touch;
        rise = '0;
        for (int i = 0; i < NP; i++) begin
            raw = (cnt[i] >= TH);
            newc[i*CW +: CW] = CW'(cnt[i]);
            if (raw != nt[i]) begin
                m_agree[i]++;
                if (m_agree[i] == DB) begin
                    nt[i]      = raw;
                    m_agree[i] = 0;
                    rise[i]    = raw;
                end
            end else begin
                m_agree[i] = 0;
            end
        end
        step();
        hit_clear  = clr_gap;
        exp_touch  = nt;
        exp_hit    = (exp_hit & ~clr_eval) | rise;
        exp_counts = newc;
        exp_sd     = 1'b1;
        step();
        hit_clear = '0;
        exp_hit   = exp_hit & ~clr_gap;
        exp_sd    = 1'b0;
        enable    = en_next;
    endtask

    task automatic set_all(input int v);
        for (int i = 0; i < NP; i++) hv[i] = v;
    endtask

    initial begin
        int sd0;
        bit en_n;
        int r;

        // Reset held with enable high.
        model_reset();
        reset  = 1'b0;
        enable = 1'b1;
        step();
        chk_en = 1;
        step();
        step();
        chk("rst_out", cs_out, 1'b0);
        chk("rst_touch", touch_level, 9'h000);
        chk("rst_hit", hit_pending, 9'h000);
        chk("rst_counts", pad_counts, 90'h0);
        chk("rst_done", scan_done, 1'b0);

        // Release reset; scans begin right away.
        step();
        reset  = 1'b1;
        enable = 1'b1;

        // Idle pads: every pad falls as soon as the line drops.
        sd0 = sd_seen;
        set_all(0);
        scan(0, 1, '0, '0, -1);
        scan(0, 1, '0, '0, -1);
        chk("idle_pulses", sd_seen - sd0, 2);
        chk("idle_pulse_ordinal", sd_cyc - scan_start + 1, 9);
        chk("idle_counts", pad_counts, {9{10'd2}});
        chk("idle_touch", touch_level, 9'h000);

        // Pad 3 touched on two consecutive scans.
        set_all(0);
        hv[3] = 15;
        scan(0, 1, '0, '0, -1);
        chk("t3_scan1_touch", touch_level, 9'h000);
        scan(0, 1, '0, '0, -1);
        chk("t3_scan2_touch", touch_level, 9'h008);
        chk("t3_scan2_hit", hit_pending, 9'h008);
        chk("t3_pad3_count", pad_counts[3*CW +: CW], 10'd17);

        // Pad 8 stuck high, pad 0 touched for one scan only, pad 3 released.
        set_all(0);
        hv[8] = STUCK;
        hv[0] = 12;
        scan(0, 1, '0, '0, -1);
        chk("glitch_touch", touch_level, 9'h008);
        set_all(0);
        hv[8] = STUCK;
        scan(0, 0, 9'h100, '0, -1);
        chk("stuck_count", pad_counts[8*CW +: CW], 10'd31);
        chk("stuck_pulse_ordinal", sd_cyc - scan_start + 1, 38);
        chk("release_touch", touch_level, 9'h100);
        chk("set_wins_hit", hit_pending, 9'h108);
        idle_clear(9'h100);
        chk("late_clear_hit", hit_pending, 9'h008);

        // Enable dropped during CHARGE: scan completes, then stays idle.
        start();
        set_all(0);
        scan(1, 0, '0, '0, -1);
        step();
        step();
        step();
        chk("drop_en_out", cs_out, 1'b0);
        chk("drop_en_done", scan_done, 1'b0);

        // Reset asserted mid-MEASURE.
        start();
        set_all(0);
        hv[5] = 20;
        scan(0, 0, '0, '0, 5);
        chk("abort_out", cs_out, 1'b0);
        chk("abort_hit", hit_pending, 9'h000);
        chk("abort_counts", pad_counts, 90'h0);
        chk("abort_touch", touch_level, 9'h000);

        // Threshold boundary: count 10 is touched, 9 is not.
        start();
        set_all(0);
        hv[1] = 8;
        hv[2] = 7;
        scan(0, 1, '0, '0, -1);
        chk("thresh_at", pad_counts[1*CW +: CW], 10'd10);
        chk("thresh_below", pad_counts[2*CW +: CW], 10'd9);

        // Randomized scans against the model.
        for (int k = 0; k < 14; k++) begin
            for (int i = 0; i < NP; i++) begin
                r = $urandom_range(0, 9);
                if (r < 3)      hv[i] = $urandom_range(0, 6);
                else if (r < 6) hv[i] = $urandom_range(7, 15);
                else if (r < 8) hv[i] = $urandom_range(16, 28);
                else            hv[i] = STUCK;
            end
            en_n = (k != 13) && ($urandom_range(0, 4) != 0);
            scan(0, en_n, NP'($urandom), NP'($urandom), -1);
            if (!en_n && k != 13) start();
        end
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
